// File: rtl/qsys_serial_endpoint.sv
// qsys_serial_endpoint
//   Serial-to-Avalon-MM bridge. A 64-bit command frame shifted in on sdi
//   (framed by sle, MSB first) is turned into one local-bus read or write;
//   the 64-bit response frame is then shifted out on sdo, with srdy marking
//   the cycle that carries bit 63.
//
//   Command frame : [63] write flag, [62:40] ignored, [32+ADDR_W-1:32] address,
//                   [31:0] write data.
//   Response frame: [63] error flag, address field echoed, [31:0] read data
//                   (read) or echoed write data (write), all other bits 0.
//
//   Ports
//     csi_MCLK_clk        clock, rising edge
//     rsi_MRST_reset_n    asynchronous active-low reset
//     sdi / sle           serial command data / frame enable
//     sdo / srdy          serial response data / response-ready strobe
//     avm_m0_*            Avalon-MM master (address, write, read, writedata,
//                         readdata, waitrequest)
//
//   Build option
//     QSYS_ENDPOINT_TIMEOUT_EN : when defined, an access stalled by
//     waitrequest for TIMEOUT cycles is abandoned and answered with the
//     error flag set and data 32'hDEADBEEF. When undefined, ACCESS waits
//     indefinitely and TIMEOUT has no effect.

module qsys_serial_endpoint #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset_n,
  input  logic              sdi,
  input  logic              sle,
  output logic              sdo,
  output logic              srdy,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_write,
  output logic              avm_m0_read,
  output logic [31:0]       avm_m0_writedata,
  input  logic [31:0]       avm_m0_readdata,
  input  logic              avm_m0_waitrequest
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    ACCESS,
    RESP,
    SHIFT_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // One register holds the command while shifting in and during the access,
  // and is reloaded with the response frame when the access completes.
  logic [63:0] shreg_q, shreg_d;
  logic [63:0] resp;
  logic        acc_done;
  logic        acc_err;

`ifdef QSYS_ENDPOINT_TIMEOUT_EN
  // Counts stalled ACCESS cycles 0..TIMEOUT-1; the TIMEOUT-th stall aborts.
  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (state_q == ACCESS && avm_m0_waitrequest) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // State and datapath registers
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    acc_done = 1'b0;
    acc_err  = 1'b0;
    resp     = '0;
    unique case (state_q)
      IDLE: begin
        if (sle) begin
          shreg_d = {63'd0, sdi};
          cnt_d   = 6'd1;
          state_d = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        if (!sle) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          shreg_d = {shreg_q[62:0], sdi};
          if (cnt_q == 6'd63) begin
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ACCESS: begin
`ifdef QSYS_ENDPOINT_TIMEOUT_EN
        acc_err = tmo_hit;
`endif
        acc_done               = !avm_m0_waitrequest || acc_err;
        resp[63]               = acc_err;
        resp[32 +: ADDR_W]     = shreg_q[32 +: ADDR_W];
        if (acc_err) begin
          resp[31:0] = 32'hDEADBEEF;
        end else if (shreg_q[63]) begin
          resp[31:0] = shreg_q[31:0];
        end else begin
          resp[31:0] = avm_m0_readdata;
        end
        if (acc_done) begin
          shreg_d = resp;
          state_d = RESP;
        end
      end
      RESP: begin
        shreg_d = {shreg_q[62:0], 1'b0};
        cnt_d   = '0;
        state_d = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        shreg_d = {shreg_q[62:0], 1'b0};
        if (cnt_q == 6'd62) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    avm_m0_read  = 1'b0;
    avm_m0_write = 1'b0;
    srdy         = 1'b0;
    sdo          = 1'b0;
    unique case (state_q)
      ACCESS: begin
        avm_m0_write = shreg_q[63];
        avm_m0_read  = !shreg_q[63];
      end
      RESP: begin
        srdy = 1'b1;
        sdo  = shreg_q[63];
      end
      SHIFT_OUT: begin
        sdo = shreg_q[63];
      end
      default: begin
      end
    endcase
  end

  assign avm_m0_address   = shreg_q[32 +: ADDR_W];
  assign avm_m0_writedata = shreg_q[31:0];

endmodule

// File: doc/qsys_serial_endpoint.md
QSYS_SERIAL_ENDPOINT -- requirements
Module: qsys_serial_endpoint

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the local-bus address taken from frame bits [32+ADDR_W-1:32].
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of waitrequest cycles tolerated per access (used only with REQ-030).
REQ-003 SHALL have ports, one per line:
 csi_MCLK_clk  in  1  single clock; all logic on its rising edge.
 rsi_MRST_reset_n  in  1  reset, asynchronous, active-low.
 sdi  in  1  serial command input, MSB first.
 sle  in  1  frame enable; high for the duration of a command frame.
 sdo  out  1  serial response output, MSB first.
 srdy  out  1  response-ready strobe.
 avm_m0_address  out  ADDR_W  local-bus address.
 avm_m0_write  out  1  write request.
 avm_m0_read  out  1  read request.
 avm_m0_writedata  out  32  write data.
 avm_m0_readdata  in  32  read data, valid when waitrequest is low.
 avm_m0_waitrequest  in  1  slave stall.

Function
REQ-004 Command frame: 64 bits; bit 63 = write flag (1 write, 0 read); bits [62:40] ignored; bits [39:32] address; bits [31:0] write data.
REQ-005 Response frame: bit 63 = error flag; bits [62:40] zero; bits [39:32] command address; bits [31:0] read data (read) or echoed write data (write).
REQ-006 States: IDLE, SHIFT_IN, ACCESS, RESP, SHIFT_OUT.
REQ-007 IDLE with sle=1: capture sdi as bit 63, bit count = 1, go to SHIFT_IN.
REQ-008 SHIFT_IN with sle=1: shift sdi in, count increments; when the 64th bit is captured, go to ACCESS next cycle.
REQ-009 SHIFT_IN with sle=0 before 64 bits: discard frame, return to IDLE; no bus access issued.
REQ-010 sle remaining high after bit 64 and sdi during ACCESS/RESP/SHIFT_OUT SHALL be ignored; a new frame starts only from IDLE.
REQ-011 ACCESS: drive address/writedata and assert exactly one of avm_m0_write or avm_m0_read per the write flag; hold all stable while avm_m0_waitrequest=1.
REQ-012 On the first ACCESS cycle with waitrequest=0: capture avm_m0_readdata (reads), deassert the request next cycle, go to RESP.
REQ-013 RESP: load the response frame, assert srdy for exactly one cycle, sdo = bit 63 in that cycle.
REQ-014 SHIFT_OUT: sdo presents bits 62..0, one per cycle, for 63 cycles, then IDLE; srdy low.
REQ-015 sdo SHALL be 0 and avm_m0_read/avm_m0_write 0 in all states other than those stated above.
REQ-016 Minimum latency last-command-bit to srdy: 2 cycles with waitrequest=0 (ACCESS one cycle, then RESP).
REQ-017 Error flag SHALL be 0 unless set per REQ-030.

Reset
REQ-018 rsi_MRST_reset_n low SHALL immediately force state IDLE, count 0, shift registers 0, sdo=0, srdy=0, avm_m0_read=0, avm_m0_write=0, avm_m0_address=0, avm_m0_writedata=0.
REQ-019 Reset asserted mid-frame or mid-access SHALL abort it; no response is sent after release.
REQ-020 Deassertion SHALL be sampled synchronously; first frame capture possible on the first clock edge after release.

Configuration
REQ-030 With QSYS_ENDPOINT_TIMEOUT_EN defined: a counter SHALL count ACCESS cycles with waitrequest=1; on reaching TIMEOUT, the request SHALL be dropped, data field set to 32'hDEADBEEF, error flag set to 1, go to RESP.
REQ-031 Without QSYS_ENDPOINT_TIMEOUT_EN: no counter; ACCESS waits indefinitely for waitrequest=0; error flag constant 0; TIMEOUT unused.

Verification
REQ-040 Write frame flag=1, addr 8'h12, data 32'hA5A5_0001, waitrequest=0 -> one avm_m0_write cycle at 0x12 with 0xA5A50001; srdy 2 cycles after bit 0; sdo frame 0x00000012_A5A50001.
REQ-041 Read frame addr 8'h34, readdata 32'hCAFEF00D, waitrequest high 3 cycles -> avm_m0_read held 4 cycles; srdy 5 cycles after bit 0; sdo frame 0x00000034_CAFEF00D.
REQ-042 sle dropped after 20 bits -> back to IDLE, no read/write pulse, srdy stays 0; next full frame processed normally.
REQ-043 Reset low during cycle 10 of SHIFT_OUT -> sdo=0, srdy=0 immediately; no further sdo activity after release until a new frame.
REQ-044 QSYS_ENDPOINT_TIMEOUT_EN, TIMEOUT=4, read with waitrequest stuck high -> read dropped after 4 cycles; response 0x80000034_DEADBEEF (addr 0x34).
REQ-045 sle held high 70 cycles with back-to-back data -> only first 64 bits used; exactly one bus access.
